// File: rtl/lap_apb_reader.sv
`default_nettype none
// ============================================================================
// Module      : lap_apb_reader
// Description : APB slave holding stopwatch lap records in a slot memory.
//               Laps can be read per slot or drained in arrival order via a
//               POP register; irq_lap stays high while unread laps remain.
// Revision    : 1.0 - initial release
// ============================================================================
module lap_apb_reader #(
  parameter int NUM_LAPS = 10,
  parameter int LAP_W    = 26
) (
  input  logic             iPCLK,
  input  logic             iRESETn,
  input  logic [LAP_W-1:0] lap,
  input  logic [3:0]       lap_addr,
  input  logic             lap_wr,
  input  logic             PSEL,
  input  logic             PENABLE,
  input  logic             PWRITE,
  input  logic [7:0]       PADDR,
  input  logic [31:0]      PWDATA,
  output logic [31:0]      PRDATA,
  output logic             PREADY,
  output logic             PSLVERR,
  output logic             irq_lap
);

  // Word indices of the register map (PADDR[7:2])
  localparam logic [5:0] c_IDX_STATUS = 6'h0A;  // 0x28
  localparam logic [5:0] c_IDX_CTRL   = 6'h0B;  // 0x2C
  localparam logic [5:0] c_IDX_POP    = 6'h0D;  // 0x34
  localparam logic [3:0] c_NUM_LAPS   = 4'(NUM_LAPS);
  localparam logic [3:0] c_LAST_SLOT  = 4'(NUM_LAPS - 1);

  logic [LAP_W-1:0]    r_slot [NUM_LAPS];
  logic [NUM_LAPS-1:0] r_valid;
  logic [3:0]          r_count;
  logic [3:0]          r_rd_ptr;
  logic [3:0]          r_last_addr;
  logic                r_overflow;
  logic                r_addr_err;
  logic                r_irq;

  logic [5:0]  w_idx;
  logic        w_rd_phase;
  logic        w_pop;
  logic        w_pop_ok;
  logic        w_clr;
  logic        w_wr_ok;
  logic        w_wr_bad;
  logic [3:0]  w_rd_ptr_nxt;
  logic [31:0] w_status;
  logic        w_unused;

  assign w_idx        = PADDR[7:2];
  assign w_rd_phase   = PSEL & PENABLE & ~PWRITE;
  assign w_pop        = w_rd_phase & (w_idx == c_IDX_POP);
  assign w_pop_ok     = w_pop & (r_count != 4'd0);
  assign w_clr        = PSEL & PENABLE & PWRITE & (w_idx == c_IDX_CTRL) & PWDATA[0];
  assign w_wr_ok      = lap_wr & (lap_addr < c_NUM_LAPS);
  assign w_wr_bad     = lap_wr & ~(lap_addr < c_NUM_LAPS);
  assign w_rd_ptr_nxt = (r_rd_ptr == c_LAST_SLOT) ? 4'd0 : r_rd_ptr + 4'd1;
  assign w_status     = {r_last_addr, 2'b00, r_addr_err, r_overflow, 4'b0000,
                         r_count, 16'(r_valid)};
  assign w_unused     = ^{PADDR[1:0], PWDATA[31:1]};

  assign PREADY  = 1'b1;
  assign PSLVERR = w_pop & (r_count == 4'd0);
  assign irq_lap = r_irq;

  // Read data mux, driven only during a read access phase
  always_comb begin
    PRDATA = 32'd0;
    if (w_rd_phase) begin
      if (w_idx < 6'(NUM_LAPS)) begin
        PRDATA = 32'(r_slot[w_idx[3:0]]);
      end else if (w_idx == c_IDX_STATUS) begin
        PRDATA = w_status;
      end else if (w_pop_ok) begin
        PRDATA = 32'(r_slot[r_rd_ptr]);
      end
    end
  end

  // Lap storage, unread count, read pointer and sticky flags; clear wins over lap writes
  always_ff @(posedge iPCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      for (int i = 0; i < NUM_LAPS; i++) r_slot[i] <= '0;
      r_valid     <= '0;
      r_count     <= 4'd0;
      r_rd_ptr    <= 4'd0;
      r_last_addr <= 4'd0;
      r_overflow  <= 1'b0;
      r_addr_err  <= 1'b0;
    end else if (w_clr) begin
      for (int i = 0; i < NUM_LAPS; i++) r_slot[i] <= '0;
      r_valid     <= '0;
      r_count     <= 4'd0;
      r_rd_ptr    <= 4'd0;
      r_last_addr <= 4'd0;
      r_overflow  <= 1'b0;
      r_addr_err  <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_slot[lap_addr]  <= lap;
        r_valid[lap_addr] <= 1'b1;
        r_last_addr       <= lap_addr;
      end
      if (w_wr_bad) begin
        r_addr_err <= 1'b1;
      end
      // A write paired with a successful pop leaves the count unchanged
      if (w_wr_ok && w_pop_ok) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end else if (w_wr_ok) begin
        if (r_count == c_NUM_LAPS) begin
          r_overflow <= 1'b1;
          r_rd_ptr   <= w_rd_ptr_nxt;   // oldest lap is discarded
        end else begin
          r_count <= r_count + 4'd1;
        end
      end else if (w_pop_ok) begin
        r_count  <= r_count - 4'd1;
        r_rd_ptr <= w_rd_ptr_nxt;
      end
    end
  end

  // Interrupt is the registered "unread laps pending" condition
  always_ff @(posedge iPCLK or negedge iRESETn) begin
    if (!iRESETn) r_irq <= 1'b0;
    else          r_irq <= (r_count != 4'd0);
  end

endmodule
`default_nettype wire

// File: tb/tb_lap_apb_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_lap_apb_reader
// Description : Directed self-checking bench for lap_apb_reader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lap_apb_reader;

  logic        iPCLK = 1'b0;
  logic        iRESETn;
  logic [25:0] lap;
  logic [3:0]  lap_addr;
  logic        lap_wr;
  logic        PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, irq_lap;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] rd;
  logic        er;

  lap_apb_reader dut (
    .iPCLK   (iPCLK),
    .iRESETn (iRESETn),
    .lap     (lap),
    .lap_addr(lap_addr),
    .lap_wr  (lap_wr),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .irq_lap (irq_lap)
  );

  always #5 iPCLK = ~iPCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Single lap write strobe, one cycle
  task automatic lap_write(input logic [3:0] a, input logic [25:0] v);
    lap = v; lap_addr = a; lap_wr = 1'b1;
    @(posedge iPCLK); #1;
    lap_wr = 1'b0;
  endtask

  // APB read; optionally strobes lap_wr during the access phase
  task automatic apb_rd(input logic [7:0] a, output logic [31:0] d, output logic e,
                        input logic wl = 1'b0, input logic [3:0] la = 4'd0,
                        input logic [25:0] lv = 26'd0);
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
    @(posedge iPCLK); #1;
    PENABLE = 1'b1;
    if (wl) begin lap = lv; lap_addr = la; lap_wr = 1'b1; end
    @(negedge iPCLK);
    d = PRDATA; e = PSLVERR;
    @(posedge iPCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; lap_wr = 1'b0;
  endtask

  // APB write; optionally strobes lap_wr during the access phase
  task automatic apb_wr(input logic [7:0] a, input logic [31:0] wd,
                        input logic wl = 1'b0, input logic [3:0] la = 4'd0,
                        input logic [25:0] lv = 26'd0);
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = wd; PENABLE = 1'b0;
    @(posedge iPCLK); #1;
    PENABLE = 1'b1;
    if (wl) begin lap = lv; lap_addr = la; lap_wr = 1'b1; end
    @(posedge iPCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; lap_wr = 1'b0;
  endtask

  initial begin
    iRESETn = 1'b0; lap = '0; lap_addr = '0; lap_wr = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    repeat (3) @(posedge iPCLK);
    #1 iRESETn = 1'b1;

    // Reset state
    chk("rst_prdata", PRDATA, 32'h0);
    chk("rst_pready", 32'(PREADY), 32'h1);
    chk("rst_irq", 32'(irq_lap), 32'h0);
    apb_rd(8'h28, rd, er);
    chk("rst_status", rd, 32'h0);
    chk("rst_pslverr", 32'(er), 32'h0);

    // Single lap to slot 0
    lap_write(4'd0, 26'h0A1B2C3);
    chk("irq_not_yet", 32'(irq_lap), 32'h0);
    @(posedge iPCLK); #1;
    chk("irq_rise", 32'(irq_lap), 32'h1);
    apb_rd(8'h00, rd, er);
    chk("lap0", rd, 32'h00A1B2C3);
    apb_rd(8'h28, rd, er);
    chk("status_one", rd, 32'h00010001);

    // Unmapped address
    apb_rd(8'h30, rd, er);
    chk("unmapped_data", rd, 32'h0);
    chk("unmapped_err", 32'(er), 32'h0);

    // Overflow: 12 laps into 0..9,0,1
    apb_wr(8'h2C, 32'h1);
    for (int i = 0; i < 12; i++) lap_write(4'(i % 10), 26'((i % 10) + 1));
    apb_rd(8'h28, rd, er);
    chk("status_ovf", rd, 32'h110A03FF);
    apb_rd(8'h14, rd, er);
    chk("lap5_random", rd, 32'h6);
    apb_rd(8'h28, rd, er);
    chk("status_after_random", rd, 32'h110A03FF);
    for (int i = 0; i < 10; i++) begin
      apb_rd(8'h34, rd, er);
      chk($sformatf("pop%0d", i), rd, 32'((i < 8) ? i + 3 : i - 7));
      chk($sformatf("pop%0d_err", i), 32'(er), 32'h0);
    end
    chk("irq_still_high", 32'(irq_lap), 32'h1);
    @(posedge iPCLK); #1;
    chk("irq_fall", 32'(irq_lap), 32'h0);
    apb_rd(8'h34, rd, er);
    chk("pop_empty_data", rd, 32'h0);
    chk("pop_empty_err", 32'(er), 32'h1);

    // Out-of-range lap address
    lap_write(4'd12, 26'h3FFFFFF);
    apb_rd(8'h28, rd, er);
    chk("status_addr_err", rd, 32'h130003FF);

    // Simultaneous write and pop at count 0, with rd_ptr at slot 3
    apb_wr(8'h2C, 32'h1);
    lap_write(4'd0, 26'h11);
    lap_write(4'd1, 26'h22);
    lap_write(4'd2, 26'h33);
    for (int i = 0; i < 3; i++) begin
      apb_rd(8'h34, rd, er);
      chk($sformatf("drain%0d", i), rd, 32'(8'h11 * (i + 1)));
    end
    apb_rd(8'h34, rd, er, 1'b1, 4'd3, 26'h1234567);
    chk("simul_err", 32'(er), 32'h1);
    chk("simul_data", rd, 32'h0);
    apb_rd(8'h28, rd, er);
    chk("status_simul", rd, 32'h3001000F);
    apb_rd(8'h34, rd, er);
    chk("pop_slot3", rd, 32'h01234567);
    chk("pop_slot3_err", 32'(er), 32'h0);

    // Clear with concurrent lap write, 4 laps stored
    for (int i = 4; i < 8; i++) lap_write(4'(i), 26'(i * 16));
    apb_wr(8'h2C, 32'h1, 1'b1, 4'd8, 26'h55);
    @(posedge iPCLK); #1;
    chk("irq_after_clear", 32'(irq_lap), 32'h0);
    apb_rd(8'h28, rd, er);
    chk("status_clear", rd, 32'h0);
    for (int i = 0; i < 10; i++) begin
      apb_rd(8'(i * 4), rd, er);
      chk($sformatf("clr_lap%0d", i), rd, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lap_apb_reader.md
# lap_apb_reader

APB slave that captures lap records from the stopwatch timer and exposes them to the CPU. Each lap write (26-bit time plus 4-bit slot address) is stored in a 10-entry lap memory. Software can read any slot randomly, or drain laps in arrival order through a pop register. The block sits between the stopwatch core and the APB bus, with a level interrupt that stays high while unread laps remain.

## Interface
- NUM_LAPS, 10, number of lap slots (valid addresses 0..NUM_LAPS-1)
- LAP_W, 26, lap record width: {hour[6:0], min[5:0], sec[5:0], sub_sec[6:0]}
- iPCLK  input  1  APB/system clock
- iRESETn  input  1  reset; asynchronous, active-low; clock iPCLK
- lap  input  26  lap record from stopwatch; stable when lap_wr=1
- lap_addr  input  4  target slot for lap
- lap_wr  input  1  single-cycle write strobe; lap/lap_addr valid in same cycle
- PSEL  input  1  APB select
- PENABLE  input  1  APB access phase
- PWRITE  input  1  APB direction (1=write)
- PADDR  input  8  APB byte address; bits [1:0] ignored
- PWDATA  input  32  APB write data
- PRDATA  output  32  APB read data
- PREADY  output  1  tied 1 (zero wait states)
- PSLVERR  output  1  APB error response
- irq_lap  output  1  registered; 1 while unread count != 0

## Operation
- Register map:
  - 0x00..0x24 LAPn (RO): {6'b0, slot n}.
  - 0x28 STATUS (RO): [9:0] valid mask, [19:16] unread count, [24] overflow, [25] addr_err, [31:28] last written addr.
  - 0x2C CTRL (WO): bit0=1 clears the block.
  - 0x34 POP (RO, side effect): returns the slot at rd_ptr.
  - All other addresses read 0 with PSLVERR=0. Writes to RO addresses are ignored.
- Lap write (lap_wr=1, lap_addr<NUM_LAPS):
  - slot[lap_addr] <= lap; valid[lap_addr] <= 1; last_addr <= lap_addr.
  - Unread count +1, saturating at NUM_LAPS.
- Lap write with lap_addr>=NUM_LAPS: no store and no count change; addr_err <= 1 (sticky).
- Overflow: a write when count==NUM_LAPS and no simultaneous pop sets overflow (sticky). Count stays at NUM_LAPS and rd_ptr advances by 1 mod NUM_LAPS, discarding the oldest lap.
- Pop (access phase: PSEL & PENABLE & ~PWRITE & PADDR==0x34):
  - If count>0: PRDATA = {6'b0, slot[rd_ptr]}; rd_ptr <= rd_ptr+1 mod NUM_LAPS (9 wraps to 0); count -1.
  - If count==0: PRDATA=0, PSLVERR=1, no state change.
- Simultaneous lap write and pop:
  - The pop uses the pre-write count and data.
  - Net count is unchanged when count>0. When count==0, count becomes 1 and the pop errors.
  - At count==NUM_LAPS, no overflow flag is set and rd_ptr advances once only.
- CTRL clear (write access, PWDATA[0]=1):
  - Zeroes all slots, valid, count, rd_ptr, overflow, addr_err and last_addr.
  - Clear has priority; a lap_wr in the same cycle is dropped.
- Random LAPn reads have no side effect on count or rd_ptr.

## Timing
- Reset values: PRDATA=0, PSLVERR=0, PREADY=1, irq_lap=0. All slots, valid, count, rd_ptr, flags and last_addr reset to 0.
- PRDATA and PSLVERR are combinational during the access phase (PSEL & PENABLE & ~PWRITE), and 0 otherwise.
- State updates (slot, count, rd_ptr, flags) occur at the iPCLK edge that ends the access phase or the lap_wr cycle.
- Readback latency:
  - A lap written at edge N is readable in an APB access phase sampled at edge N+1 or later.
  - irq_lap rises 1 cycle after the write edge (registered from count).
  - irq_lap falls 1 cycle after the pop or clear that makes count 0.
- Reset asserted mid-transfer returns all state to reset values immediately (asynchronous). A partially completed APB transfer has no effect.
- Back-to-back pops on consecutive APB transfers are supported, one per access phase.

## Test plan
- Reset, then read STATUS -> 0x00000000; irq_lap=0; PREADY=1.
- lap_wr with lap_addr=0, lap=0x0A1B2C3 -> LAP0 reads 0x00A1B2C3; STATUS count=1, valid=0x001, last_addr=0; irq_lap=1 one cycle later.
- Write 12 laps to addrs 0..9 then 0,1 (lap=addr+1) -> count=10, overflow=1; POP sequence returns slots 2..9,0,1 (values 3..10,1,2); 11th POP gives PSLVERR=1 and PRDATA=0; irq_lap falls after the 10th pop.
- lap_wr with lap_addr=12 -> no valid bit set, addr_err=1, count unchanged.
- With count=0, lap_wr to addr 3 in the same cycle as a POP access -> PSLVERR=1; count=1 afterwards; next POP returns slot 3.
- With 4 laps stored, write CTRL=0x1 in the same cycle as lap_wr -> STATUS=0, all LAPn read 0, irq_lap=0 next cycle.
